// File: rtl/key_periph_pkg.sv
// Shared constants for the push-button input peripheral: bus region,
// register word offsets and per-key press counter width.
package key_periph_pkg;

  localparam logic [2:0] KEY_REGION = 3'b101;

  localparam logic [1:0] OFS_STATE = 2'd0;
  localparam logic [1:0] OFS_EDGE  = 2'd1;
  localparam logic [1:0] OFS_COUNT = 2'd2;
  localparam logic [1:0] OFS_MASK  = 2'd3;

  localparam int COUNT_W = 8;

endpackage

// File: rtl/key_debouncer.sv
// One push-button: synchroniser into clk, stability counter, accepted level
// and a one-cycle pulse on every accepted press (0->1 of the level).
module key_debouncer
  import key_periph_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic level,
  output logic press_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   stable_q, stable_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pulse_q, pulse_d;
  logic                   synced;

  // Synchroniser resets to the released (high) level so reset never looks like a press.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], key_n};
  assign synced = ~sync_q[SYNC_STAGES-1];

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    pulse_d  = 1'b0;
    if (synced == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == C_MAX) begin
      stable_d = synced;
      cnt_d    = '0;
      pulse_d  = synced;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '1;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign level       = stable_q;
  assign press_pulse = pulse_q;

endmodule

// File: rtl/key_input_periph.sv
// Memory-mapped push-button peripheral: debounced STATE, sticky W1C EDGE flags,
// per-key press counters and an interrupt MASK, with a registered level irq.
module key_input_periph
  import key_periph_pkg::*;
#(
  parameter int NKEYS           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NKEYS-1:0] key_n,
  input  logic             sel,
  input  logic [3:0]       address,
  input  logic             write_enable,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             rdata_valid,
  output logic             irq
);

  localparam int NCNT = (NKEYS > 4) ? 4 : NKEYS;

  logic [NKEYS-1:0]   level;
  logic [NKEYS-1:0]   press_pulse;
  logic [NKEYS-1:0]   edge_q, edge_d;
  logic [NKEYS-1:0]   mask_q, mask_d;
  logic [COUNT_W-1:0] count_q [NCNT];
  logic [COUNT_W-1:0] count_d [NCNT];
  logic               irq_q, irq_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rdata_valid_q, rdata_valid_d;
  logic [31:0]        rd_word;
  logic               wr_hit, rd_req, wr_edge, wr_count, wr_mask;
  logic               unused_bits;

  for (genvar k = 0; k < NKEYS; k++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_deb (
      .clk        (clk),
      .reset      (reset),
      .key_n      (key_n[k]),
      .level      (level[k]),
      .press_pulse(press_pulse[k])
    );
  end

  assign wr_hit   = sel && write_enable;
  assign rd_req   = sel && !write_enable;
  assign wr_edge  = wr_hit && (address[3:2] == OFS_EDGE);
  assign wr_count = wr_hit && (address[3:2] == OFS_COUNT);
  assign wr_mask  = wr_hit && (address[3:2] == OFS_MASK);

  assign unused_bits = ^{address[1:0], wdata[31:NKEYS]};

  // A press landing on the same edge as a clear wins, for both flags and counters.
  always_comb begin
    edge_d = (edge_q & ~(wr_edge ? wdata[NKEYS-1:0] : '0)) | press_pulse;
    mask_d = wr_mask ? wdata[NKEYS-1:0] : mask_q;
    irq_d  = |(edge_q & mask_q);
    for (int k = 0; k < NCNT; k++) begin
      count_d[k] = count_q[k];
      if (wr_count && wdata[k]) begin
        count_d[k] = press_pulse[k] ? COUNT_W'(1) : '0;
      end else if (press_pulse[k]) begin
        count_d[k] = count_q[k] + COUNT_W'(1);
      end
    end
  end

  always_comb begin
    rd_word = '0;
    case (address[3:2])
      OFS_STATE: rd_word[NKEYS-1:0] = level;
      OFS_EDGE:  rd_word[NKEYS-1:0] = edge_q;
      OFS_COUNT: begin
        for (int k = 0; k < NCNT; k++) begin
          rd_word[COUNT_W*k +: COUNT_W] = count_q[k];
        end
      end
      OFS_MASK:  rd_word[NKEYS-1:0] = mask_q;
      default:   rd_word = '0;
    endcase
    rdata_d       = rd_req ? rd_word : rdata_q;
    rdata_valid_d = rd_req;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_q        <= '0;
      mask_q        <= '0;
      irq_q         <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      for (int k = 0; k < NCNT; k++) begin
        count_q[k] <= '0;
      end
    end else begin
      edge_q        <= edge_d;
      mask_q        <= mask_d;
      irq_q         <= irq_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      for (int k = 0; k < NCNT; k++) begin
        count_q[k] <= count_d[k];
      end
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_key_input_periph.sv
// Scenario bench for key_input_periph with DEBOUNCE_CYCLES=8, SYNC_STAGES=2:
// expected read data is queued when a read is issued and compared on return.
module tb_key_input_periph;

  localparam int NKEYS = 4;
  localparam int DC    = 8;
  localparam int SS    = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NKEYS-1:0] key_n = '1;
  logic             sel = 1'b0;
  logic [3:0]       address = '0;
  logic             write_enable = 1'b0;
  logic [31:0]      wdata = '0;
  logic [31:0]      rdata;
  logic             rdata_valid;
  logic             irq;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  key_input_periph #(
    .NKEYS(NKEYS), .DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .sel(sel), .address(address),
    .write_enable(write_enable), .wdata(wdata), .rdata(rdata),
    .rdata_valid(rdata_valid), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    sel = 1'b1; write_enable = 1'b1; address = a; wdata = d;
    tick();
    sel = 1'b0; write_enable = 1'b0; wdata = '0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d, output logic v);
    sel = 1'b1; write_enable = 1'b0; address = a;
    tick();
    sel = 1'b0;
    d = rdata;
    v = rdata_valid;
  endtask

  task automatic wait_pulse(input int k, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (dut.press_pulse[k]) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    logic [31:0] d, e;
    logic v;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'h0);
      bus_read(4'(i * 4), d, v);
      e = exp_q.pop_front();
      checks++;
      if (v !== 1'b1) begin errors++; $display("[TB] FAIL reset_valid%0d: got %b expected 1", i, v); end
      checks++;
      if (d !== e) begin errors++; $display("[TB] FAIL reset_read%0d: got %h expected %h", i, d, e); end
      tick();
      checks++;
      if (rdata_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid_drop%0d: got %b expected 0", i, rdata_valid); end
    end
  endtask

  task automatic test_press();
    logic [31:0] d, e;
    logic v, found;
    int n;
    key_n[1] = 1'b0;
    n = 0; found = 1'b0;
    while (!found && n < 20) begin
      bus_read(4'h0, d, v);
      n++;
      if (d === 32'h2) found = 1'b1;
    end
    checks++;
    if (!found || n < 10 || n > 12) begin errors++; $display("[TB] FAIL press_latency: got %0d reads (found=%b) expected 11", n, found); end
    repeat (20 - n) tick();
    exp_q.push_back(32'h2);
    bus_read(4'h4, d, v);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("[TB] FAIL press_edge: got %h expected %h", d, e); end
    exp_q.push_back(32'h0000_0100);
    bus_read(4'h8, d, v);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("[TB] FAIL press_count: got %h expected %h", d, e); end
    key_n[1] = 1'b1;
    repeat (15) tick();
    exp_q.push_back(32'h0);
    bus_read(4'h0, d, v);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("[TB] FAIL release_state: got %h expected %h", d, e); end
    exp_q.push_back(32'h2);
    bus_read(4'h4, d, v);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("[TB] FAIL release_edge: got %h expected %h", d, e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h2);
    exp_q.push_back(32'h0000_0100);
    exp_q.push_back(32'h0);
    sel = 1'b1; write_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      address = 4'(i * 4);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (rdata_valid !== 1'b1 || rdata !== e) begin
        errors++;
        $display("[TB] FAIL b2b_read%0d: got valid=%b data=%h expected valid=1 data=%h", i, rdata_valid, rdata, e);
      end
    end
    sel = 1'b0;
    tick();
  endtask

  task automatic test_glitch();
    logic [31:0] d, e;
    logic v;
    bus_write(4'h4, 32'hF);
    bus_write(4'h8, 32'hF);
    repeat (3) begin
      key_n[0] = 1'b0;
      repeat (5) tick();
      key_n[0] = 1'b1;
      repeat (3) tick();
    end
    repeat (12) tick();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'h0);
      bus_read(4'(i * 4), d, v);
      e = exp_q.pop_front();
      checks++;
      if (d !== e) begin errors++; $display("[TB] FAIL glitch_read%0d: got %h expected %h", i, d, e); end
    end
  endtask

  task automatic test_writes();
    logic [31:0] d, e;
    logic v;
    bus_write(4'h0, 32'hF);
    exp_q.push_back(32'h0);
    bus_read(4'h0, d, v);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("[TB] FAIL state_ro: got %h expected %h", d, e); end
    bus_write(4'hC, 32'hFFFF_FFF5);
    exp_q.push_back(32'h5);
    bus_read(4'hC, d, v);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("[TB] FAIL mask_rw: got %h expected %h", d, e); end
    sel = 1'b0; write_enable = 1'b1; address = 4'hC; wdata = 32'hA;
    tick();
    write_enable = 1'b0; wdata = '0;
    exp_q.push_back(32'h5);
    bus_read(4'hC, d, v);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("[TB] FAIL unselected_write: got %h expected %h", d, e); end
  endtask

  task automatic test_irq();
    logic [31:0] d, e;
    logic v, found, prev_irq;
    int n;
    bus_write(4'hC, 32'h2);
    exp_q.push_back(32'h2);
    bus_read(4'hC, d, v);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("[TB] FAIL irq_mask: got %h expected %h", d, e); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_idle: got %b expected 0", irq); end
    key_n[1] = 1'b0;
    n = 0; found = 1'b0; prev_irq = irq;
    while (!found && n < 25) begin
      bus_read(4'h4, d, v);
      n++;
      if (d[1] === 1'b1) found = 1'b1;
      else prev_irq = irq;
    end
    checks++;
    if (!found || irq !== 1'b1 || prev_irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL irq_rise: got found=%b irq=%b prev=%b expected found=1 irq=1 prev=0", found, irq, prev_irq);
    end
    key_n[1] = 1'b1;
    repeat (15) tick();
    bus_write(4'h4, 32'h2);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_hold: got %b expected 1", irq); end
    tick();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_fall: got %b expected 0", irq); end
    exp_q.push_back(32'h0);
    bus_read(4'h4, d, v);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("[TB] FAIL irq_edge_clear: got %h expected %h", d, e); end
  endtask

  task automatic test_same_cycle();
    logic [31:0] d, e;
    logic v, ok;
    bus_write(4'h4, 32'hF);
    bus_write(4'h8, 32'hF);
    bus_write(4'hC, 32'h0);
    key_n[0] = 1'b0;
    wait_pulse(0, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("[TB] FAIL pulse0_timeout: got %b expected 1", ok); end
    bus_write(4'h4, 32'h1);
    exp_q.push_back(32'h1);
    bus_read(4'h4, d, v);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("[TB] FAIL edge_set_wins: got %h expected %h", d, e); end
    exp_q.push_back(32'h1);
    bus_read(4'h8, d, v);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("[TB] FAIL count_first: got %h expected %h", d, e); end
    key_n[0] = 1'b1;
    repeat (15) tick();
    key_n[0] = 1'b0;
    wait_pulse(0, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("[TB] FAIL pulse0b_timeout: got %b expected 1", ok); end
    bus_write(4'h8, 32'h1);
    exp_q.push_back(32'h1);
    bus_read(4'h8, d, v);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("[TB] FAIL count_clear_press: got %h expected %h", d, e); end
    key_n[0] = 1'b1;
    repeat (15) tick();
  endtask

  task automatic test_wrap();
    logic [31:0] d, e;
    logic v;
    bus_write(4'h8, 32'hF);
    repeat (255) begin
      key_n[3] = 1'b0;
      repeat (12) tick();
      key_n[3] = 1'b1;
      repeat (12) tick();
    end
    exp_q.push_back(32'hFF00_0000);
    bus_read(4'h8, d, v);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("[TB] FAIL count_255: got %h expected %h", d, e); end
    key_n[3] = 1'b0;
    repeat (12) tick();
    key_n[3] = 1'b1;
    repeat (12) tick();
    exp_q.push_back(32'h0);
    bus_read(4'h8, d, v);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("[TB] FAIL count_wrap: got %h expected %h", d, e); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, e;
    logic v, found;
    int n;
    key_n[2] = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'h0);
      bus_read(4'(i * 4), d, v);
      e = exp_q.pop_front();
      checks++;
      if (d !== e) begin errors++; $display("[TB] FAIL midreset_read%0d: got %h expected %h", i, d, e); end
    end
    n = 4; found = 1'b0;
    while (!found && n < 25) begin
      bus_read(4'h0, d, v);
      n++;
      if (d === 32'h4) found = 1'b1;
    end
    checks++;
    if (!found || n < 8 || n > 13) begin errors++; $display("[TB] FAIL midreset_latency: got %0d cycles (found=%b) expected 11", n, found); end
    exp_q.push_back(32'h4);
    bus_read(4'h4, d, v);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("[TB] FAIL midreset_edge: got %h expected %h", d, e); end
    exp_q.push_back(32'h0001_0000);
    bus_read(4'h8, d, v);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("[TB] FAIL midreset_count: got %h expected %h", d, e); end
    key_n[2] = 1'b1;
    repeat (15) tick();
  endtask

  initial begin
    test_reset();
    test_press();
    test_back_to_back();
    test_glitch();
    test_writes();
    test_irq();
    test_same_cycle();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
